// File: rtl/axi_lite_clint_slave_pkg.sv
// Shared definitions for the CLINT AXI-lite responder: register offsets,
// response codes, FSM state encodings, address decode and byte-strobe merge.
package ClintStruct;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_WAIT_W  = 2'd1,
    WR_WAIT_AW = 2'd2,
    WR_RESP    = 2'd3
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

  typedef enum logic [1:0] {
    SEL_NONE     = 2'd0,
    SEL_MSIP     = 2'd1,
    SEL_MTIMECMP = 2'd2,
    SEL_MTIME    = 2'd3
  } reg_sel_e;

  typedef struct packed {
    logic [1:0] resp;
    reg_sel_e   sel;
  } dec_t;

  // Window check first, then alignment, then the three mapped offsets.
  function automatic dec_t decode(input logic [63:0] addr, input logic [63:0] base);
    dec_t        d;
    logic [63:0] off;
    off    = addr - base;
    d.resp = RESP_DECERR;
    d.sel  = SEL_NONE;
    if ((addr < base) || (off > 64'h0000_0000_0000_FFFF)) begin
      d.resp = RESP_DECERR;
    end else if (addr[2:0] != 3'b000) begin
      d.resp = RESP_SLVERR;
    end else begin
      case (off[15:0])
        MSIP_OFF:     begin d.resp = RESP_OKAY; d.sel = SEL_MSIP;     end
        MTIMECMP_OFF: begin d.resp = RESP_OKAY; d.sel = SEL_MTIMECMP; end
        MTIME_OFF:    begin d.resp = RESP_OKAY; d.sel = SEL_MTIME;    end
        default:      begin d.resp = RESP_DECERR; d.sel = SEL_NONE;   end
      endcase
    end
    return d;
  endfunction

  function automatic logic [63:0] strb_merge(input logic [63:0] old_v,
                                             input logic [63:0] new_v,
                                             input logic [7:0]  strb);
    logic [63:0] r;
    r = old_v;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) begin
        r[8*i +: 8] = new_v[8*i +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_lite_clint_slave_timer_regs.sv
// CLINT register file: free-running mtime, mtimecmp, msip and the mtip compare.
// Byte strobes are honoured only when CLINT_WSTRB_EN is defined.
module clint_timer_regs
  import ClintStruct::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        wr_en_i,
  input  reg_sel_e    wr_sel_i,
  input  logic [63:0] wr_data_i,
  input  logic [7:0]  wr_strb_i,
  output logic [63:0] mtime_o,
  output logic [63:0] mtimecmp_o,
  output logic        msip_o,
  output logic        mtip_o
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic [7:0]  eff_strb_s;
  logic [63:0] msip_merged_s;

`ifdef CLINT_WSTRB_EN
  assign eff_strb_s = wr_strb_i;
`else
  logic strb_unused_s;
  assign strb_unused_s = ^wr_strb_i;
  assign eff_strb_s    = 8'hFF;
`endif

  assign msip_merged_s = strb_merge({63'd0, msip_q}, wr_data_i, eff_strb_s);

  // Next-state: mtime counts every cycle unless a write to it loads a new value.
  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr_en_i) begin
      case (wr_sel_i)
        SEL_MSIP:     msip_d     = msip_merged_s[0];
        SEL_MTIMECMP: mtimecmp_d = strb_merge(mtimecmp_q, wr_data_i, eff_strb_s);
        SEL_MTIME:    mtime_d    = strb_merge(mtime_q, wr_data_i, eff_strb_s);
        default:      mtime_d    = mtime_q + 64'd1;
      endcase
    end else begin
      msip_d = msip_q;
    end
  end

  // Register state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
    end
  end

  assign mtime_o    = mtime_q;
  assign mtimecmp_o = mtimecmp_q;
  assign msip_o     = msip_q;
  assign mtip_o     = (mtime_q >= mtimecmp_q);

endmodule

// File: rtl/axi_lite_clint_slave.sv
// AXI-lite slave for the CLINT: independent write and read FSMs plus decode.
// Optional build macro: CLINT_WSTRB_EN (honour per-byte write strobes).
module axi_lite_clint_slave
  import ClintStruct::*;
#(
  parameter int          ADDR_WIDTH = 64,
  parameter int          DATA_WIDTH = 64,
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_0200_0000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [7:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  mtip,
  output logic                  msip,
  output logic [63:0]           mtime
);

  wr_state_e   wr_state_q, wr_state_d;
  logic [63:0] awaddr_q, awaddr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        commit_s;
  logic [63:0] cmt_addr_s, cmt_data_s;
  logic [7:0]  cmt_strb_s;
  dec_t        wdec_s;

  rd_state_e   rd_state_q, rd_state_d;
  logic [63:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  dec_t        rdec_s;
  logic [63:0] rd_val_s;

  logic [63:0] aw_addr_s, ar_addr_s;
  logic [63:0] mtime_s, mtimecmp_s;
  logic        msip_s, mtip_s;

  assign aw_addr_s = 64'(awaddr);
  assign ar_addr_s = 64'(araddr);

  // Write FSM: the completing handshake picks live or latched address/data.
  always_comb begin
    wr_state_d = wr_state_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    commit_s   = 1'b0;
    cmt_addr_s = awaddr_q;
    cmt_data_s = wdata_q;
    cmt_strb_s = wstrb_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (awvalid && wvalid) begin
          commit_s   = 1'b1;
          cmt_addr_s = aw_addr_s;
          cmt_data_s = 64'(wdata);
          cmt_strb_s = wstrb;
          wr_state_d = WR_RESP;
        end else if (awvalid) begin
          awaddr_d   = aw_addr_s;
          wr_state_d = WR_WAIT_W;
        end else if (wvalid) begin
          wdata_d    = 64'(wdata);
          wstrb_d    = wstrb;
          wr_state_d = WR_WAIT_AW;
        end else begin
          wr_state_d = WR_IDLE;
        end
      end
      WR_WAIT_W: begin
        if (wvalid) begin
          commit_s   = 1'b1;
          cmt_data_s = 64'(wdata);
          cmt_strb_s = wstrb;
          wr_state_d = WR_RESP;
        end else begin
          wr_state_d = WR_WAIT_W;
        end
      end
      WR_WAIT_AW: begin
        if (awvalid) begin
          commit_s   = 1'b1;
          cmt_addr_s = aw_addr_s;
          wr_state_d = WR_RESP;
        end else begin
          wr_state_d = WR_WAIT_AW;
        end
      end
      WR_RESP: begin
        if (bready) begin
          wr_state_d = WR_IDLE;
        end else begin
          wr_state_d = WR_RESP;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
    wdec_s = decode(cmt_addr_s, BASE_ADDR);
    if (commit_s) begin
      bresp_d = wdec_s.resp;
    end else begin
      bresp_d = bresp_q;
    end
  end

  // Write-channel state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state_q <= WR_IDLE;
      awaddr_q   <= 64'd0;
      wdata_q    <= 64'd0;
      wstrb_q    <= 8'd0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
    end
  end

  assign awready = (wr_state_q == WR_IDLE) || (wr_state_q == WR_WAIT_AW);
  assign wready  = (wr_state_q == WR_IDLE) || (wr_state_q == WR_WAIT_W);
  assign bvalid  = (wr_state_q == WR_RESP);
  assign bresp   = bresp_q;

  // Read mux sees pre-edge register values, so a same-cycle write reads old data.
  always_comb begin
    rdec_s = decode(ar_addr_s, BASE_ADDR);
    case (rdec_s.sel)
      SEL_MSIP:     rd_val_s = {63'd0, msip_s};
      SEL_MTIMECMP: rd_val_s = mtimecmp_s;
      SEL_MTIME:    rd_val_s = mtime_s;
      default:      rd_val_s = 64'd0;
    endcase
  end

  // Read FSM: capture response on AR handshake, hold until rready.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (arvalid) begin
          rresp_d    = rdec_s.resp;
          rdata_d    = rd_val_s;
          rd_state_d = RD_RESP;
        end else begin
          rd_state_d = RD_IDLE;
        end
      end
      RD_RESP: begin
        if (rready) begin
          rd_state_d = RD_IDLE;
        end else begin
          rd_state_d = RD_RESP;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Read-channel state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_state_q <= RD_IDLE;
      rdata_q    <= 64'd0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign arready = (rd_state_q == RD_IDLE);
  assign rvalid  = (rd_state_q == RD_RESP);
  assign rdata   = DATA_WIDTH'(rdata_q);
  assign rresp   = rresp_q;

  clint_timer_regs u_regs (
    .clk        (clk),
    .rstn       (rstn),
    .wr_en_i    (commit_s && (wdec_s.resp == RESP_OKAY)),
    .wr_sel_i   (wdec_s.sel),
    .wr_data_i  (cmt_data_s),
    .wr_strb_i  (cmt_strb_s),
    .mtime_o    (mtime_s),
    .mtimecmp_o (mtimecmp_s),
    .msip_o     (msip_s),
    .mtip_o     (mtip_s)
  );

  assign mtime = mtime_s;
  assign mtip  = mtip_s;
  assign msip  = msip_s;

endmodule

// File: tb/tb_axi_lite_clint_slave.sv
// Self-checking bench for axi_lite_clint_slave: directed scenarios plus random
// traffic checked against a cycle-count based model of the CLINT registers.
`timescale 1ns/1ps
module tb_axi_lite_clint_slave;

  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rstn;
  logic [63:0] awaddr, wdata, araddr, rdata, mtime;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, mtip, msip;
  logic [7:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int errors = 0;
  int checks = 0;

  logic [63:0] cyc;
  logic [63:0] m_base, m_edge, m_cmp;
  logic        m_msip;

  axi_lite_clint_slave dut (
    .clk(clk), .rstn(rstn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .mtip(mtip), .msip(msip), .mtime(mtime)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; mtime model is a linear function of it.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 64'd0;
    else       cyc <= cyc + 64'd1;
  end

  function automatic logic [63:0] mtime_at(input logic [63:0] edges);
    return m_base + (edges - m_edge);
  endfunction

  function automatic logic [1:0] exp_resp(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
    if (a < BASE || a > BASE + 64'hFFFF) return 2'b11;
    if (a % 64'd8 != 64'd0) return 2'b10;
    if (off == 64'h0 || off == 64'h4000 || off == 64'hBFF8) return 2'b00;
    return 2'b11;
  endfunction

  function automatic logic [63:0] exp_read(input logic [63:0] a, input logic [63:0] hs);
    if (exp_resp(a) != 2'b00) return 64'd0;
    if (a - BASE == 64'h0)    return {63'd0, m_msip};
    if (a - BASE == 64'h4000) return m_cmp;
    return mtime_at(hs);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = n;
`ifdef CLINT_WSTRB_EN
    for (int i = 0; i < 8; i++) r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
`else
    if (s == 8'h00) r = n;
    r = n | (o & 64'd0);
`endif
    return r;
  endfunction

  task automatic model_write(input logic [63:0] a, input logic [63:0] d,
                             input logic [7:0] s, input logic [63:0] cc);
    logic [63:0] m;
    if (exp_resp(a) == 2'b00) begin
      if (a - BASE == 64'h0) begin
        m = merge({63'd0, m_msip}, d, s);
        m_msip = m[0];
      end else if (a - BASE == 64'h4000) begin
        m_cmp = merge(m_cmp, d, s);
      end else begin
        m_base = merge(mtime_at(cc - 64'd1), d, s);
        m_edge = cc;
      end
    end
  endtask

  task automatic model_reset();
    m_base = 64'd0; m_edge = 64'd0; m_cmp = ONES; m_msip = 1'b0;
  endtask

  task automatic do_read(input logic [63:0] a, output logic [63:0] d, output logic [1:0] r,
                         output bit ok, output logic [63:0] hs);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    hs = cyc;
    @(negedge clk);
    arvalid = 1'b0;
    ok = rvalid; d = rdata; r = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
  task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                          input int lead, input int hold, output logic [1:0] b,
                          output int bcnt, output logic [63:0] cc);
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s;
    if (lead == 0) begin
      awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;
    end else if (lead > 0) begin
      wvalid = 1'b1; @(negedge clk); wvalid = 1'b0;
      repeat (lead - 1) @(negedge clk);
      awvalid = 1'b1; @(negedge clk); awvalid = 1'b0;
    end else begin
      awvalid = 1'b1; @(negedge clk); awvalid = 1'b0;
      repeat (-lead - 1) @(negedge clk);
      wvalid = 1'b1; @(negedge clk); wvalid = 1'b0;
    end
    cc = cyc;
    bcnt = 0;
    for (int i = 0; i <= hold; i++) begin
      if (bvalid) bcnt++;
      if (i < hold) @(negedge clk);
    end
    b = bresp; bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if ({awready, wready, arready} !== 3'b111) begin errors++;
      $display("FAIL reset_readies: got %b want 111", {awready, wready, arready}); end
    checks++; if ({bvalid, rvalid, bresp, rresp} !== 6'b0) begin errors++;
      $display("FAIL reset_resp: got %b want 000000", {bvalid, rvalid, bresp, rresp}); end
    checks++; if (rdata !== 64'd0 || mtime !== 64'd0) begin errors++;
      $display("FAIL reset_data: rdata %h mtime %h want 0", rdata, mtime); end
    checks++; if ({mtip, msip} !== 2'b00) begin errors++;
      $display("FAIL reset_irq: got %b want 00", {mtip, msip}); end
  endtask

  task automatic test_mtime_read();
    logic [63:0] d, hs; logic [1:0] r; bit ok;
    while (cyc < 64'd9) @(negedge clk);
    do_read(BASE + 64'hBFF8, d, r, ok, hs);
    checks++; if (!ok || r !== 2'b00 || d !== 64'd10) begin errors++;
      $display("FAIL mtime_read10: rvalid %0b rresp %b rdata %0d want 1 00 10", ok, r, d); end
    checks++; if (mtip !== 1'b0) begin errors++;
      $display("FAIL mtime_read10_mtip: got %b want 0", mtip); end
  endtask

  task automatic test_timer_cmp();
    logic [1:0] b; int bc; logic [63:0] cc; bit rose;
    do_write(BASE + 64'h4000, 64'h20, 8'hFF, 0, 0, b, bc, cc);
    model_write(BASE + 64'h4000, 64'h20, 8'hFF, cc);
    checks++; if (b !== 2'b00 || bc !== 1) begin errors++;
      $display("FAIL cmp_write_resp: bresp %b bvalid_cycles %0d want 00 1", b, bc); end
    rose = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++; if (mtip !== (mtime_at(cyc) >= m_cmp) || mtime !== mtime_at(cyc)) begin errors++;
        $display("FAIL cmp_track: mtip %b mtime %h want %b %h", mtip,
                 mtime, (mtime_at(cyc) >= m_cmp), mtime_at(cyc)); end
      if (mtime_at(cyc) == 64'h20 && mtip === 1'b1) rose = 1'b1;
    end
    checks++; if (!rose) begin errors++;
      $display("FAIL cmp_rise_at_20: got 0 want 1"); end
  endtask

  task automatic test_w_before_aw();
    int bc;
    @(negedge clk);
    wdata = 64'd1; wstrb = 8'hFF; wvalid = 1'b1;
    @(negedge clk); wvalid = 1'b0;
    checks++; if ({awready, wready} !== 2'b10) begin errors++;
      $display("FAIL wfirst_readies: got %b want 10", {awready, wready}); end
    repeat (2) begin
      @(negedge clk);
      checks++; if (msip !== 1'b0 || bvalid !== 1'b0) begin errors++;
        $display("FAIL wfirst_early: msip %b bvalid %b want 0 0", msip, bvalid); end
    end
    awaddr = BASE; awvalid = 1'b1;
    @(negedge clk); awvalid = 1'b0; m_msip = 1'b1;
    checks++; if (msip !== 1'b1) begin errors++;
      $display("FAIL wfirst_msip: got %b want 1", msip); end
    bc = 0;
    for (int i = 0; i < 5; i++) begin if (bvalid) bc++; @(negedge clk); end
    checks++; if (bc !== 5 || bvalid !== 1'b1 || bresp !== 2'b00) begin errors++;
      $display("FAIL wfirst_bhold: cycles %0d bvalid %b bresp %b want 5 1 00", bc, bvalid, bresp); end
    bready = 1'b1; @(negedge clk); bready = 1'b0;
    checks++; if (bvalid !== 1'b0 || awready !== 1'b1) begin errors++;
      $display("FAIL wfirst_bdone: bvalid %b awready %b want 0 1", bvalid, awready); end
  endtask

  task automatic test_errors();
    logic [63:0] d, hs, cc; logic [1:0] r; bit ok; int bc;
    do_read(BASE + 64'h4, d, r, ok, hs);
    checks++; if (!ok || r !== 2'b10 || d !== 64'd0) begin errors++;
      $display("FAIL err_slverr: rresp %b rdata %h want 10 0", r, d); end
    do_read(BASE + 64'h10000, d, r, ok, hs);
    checks++; if (!ok || r !== 2'b11 || d !== 64'd0) begin errors++;
      $display("FAIL err_decerr_rd: rresp %b rdata %h want 11 0", r, d); end
    do_write(BASE + 64'h8000, {$urandom, $urandom}, 8'hFF, 0, 0, r, bc, cc);
    checks++; if (r !== 2'b11) begin errors++;
      $display("FAIL err_decerr_wr: bresp %b want 11", r); end
    do_read(BASE + 64'h4000, d, r, ok, hs);
    checks++; if (r !== 2'b00 || d !== m_cmp || msip !== m_msip || mtime !== mtime_at(cyc)) begin
      errors++; $display("FAIL err_nochange: cmp %h msip %b want %h %b", d, msip, m_cmp, m_msip); end
  endtask

  task automatic test_wrap();
    logic [1:0] b; int bc; logic [63:0] cc;
    do_write(BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, 0, b, bc, cc);
    model_write(BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, cc);
    checks++; if (mtime !== ONES || mtip !== 1'b1) begin errors++;
      $display("FAIL wrap_ff: mtime %h mtip %b want %h 1", mtime, mtip, ONES); end
    @(negedge clk);
    checks++; if (mtime !== 64'd0 || mtip !== 1'b0) begin errors++;
      $display("FAIL wrap_zero: mtime %h mtip %b want 0 0", mtime, mtip); end
  endtask

  task automatic test_wstrb();
    logic [1:0] b, r; int bc; logic [63:0] cc, d, hs, nd, want; bit ok;
    do_write(BASE + 64'h4000, ONES, 8'hFF, 0, 0, b, bc, cc);
    nd = {$urandom, $urandom};
    nd[7:0] = 8'hAB;
    do_write(BASE + 64'h4000, nd, 8'h01, 0, 0, b, bc, cc);
`ifdef CLINT_WSTRB_EN
    want = 64'hFFFF_FFFF_FFFF_FFAB;
`else
    want = nd;
`endif
    m_cmp = want;
    do_read(BASE + 64'h4000, d, r, ok, hs);
    checks++; if (r !== 2'b00 || d !== want) begin errors++;
      $display("FAIL wstrb_cmp: rdata %h want %h", d, want); end
  endtask

  task automatic test_simul();
    logic [63:0] old_cmp, nd;
    old_cmp = m_cmp;
    nd = {$urandom, $urandom};
    @(negedge clk);
    araddr = BASE + 64'h4000; arvalid = 1'b1;
    awaddr = BASE + 64'h4000; awvalid = 1'b1; wdata = nd; wstrb = 8'hFF; wvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    m_cmp = nd;
    checks++; if (!rvalid || !bvalid || rdata !== old_cmp) begin errors++;
      $display("FAIL simul_old: rvalid %b bvalid %b rdata %h want 1 1 %h", rvalid, bvalid, rdata, old_cmp); end
    repeat (3) begin
      @(negedge clk);
      checks++; if (!rvalid || rdata !== old_cmp) begin errors++;
        $display("FAIL rdata_stable: rvalid %b rdata %h want 1 %h", rvalid, rdata, old_cmp); end
    end
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] d, hs; logic [1:0] r; bit ok;
    do_read(BASE + 64'hBFF8, d, r, ok, hs);
    checks++; if (arready !== 1'b1) begin errors++;
      $display("FAIL b2b_arready: got %b want 1", arready); end
    do_read(BASE + 64'h4000, d, r, ok, hs);
    checks++; if (!ok || d !== m_cmp) begin errors++;
      $display("FAIL b2b_second: rdata %h want %h", d, m_cmp); end
  endtask

  task automatic test_random();
    logic [63:0] a, d, hs, cc, rd; logic [7:0] s; logic [1:0] b, rr; bit ok; int bc, hold, lead;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 7))
        0: a = BASE;
        1: a = BASE + 64'h4000;
        2: a = BASE + 64'hBFF8;
        3: a = BASE + 64'h0004;
        4: a = BASE + 64'h8000;
        5: a = BASE + 64'h10000;
        6: a = BASE - 64'h8;
        default: a = BASE + 64'h4000;
      endcase
      d = {$urandom, $urandom};
      s = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        lead = int'($urandom_range(0, 4)) - 2;
        hold = int'($urandom_range(0, 2));
        do_write(a, d, s, lead, hold, b, bc, cc);
        model_write(a, d, s, cc);
        checks++; if (b !== exp_resp(a) || bc !== hold + 1) begin errors++;
          $display("FAIL rnd_write: addr %h bresp %b bcyc %0d want %b %0d", a, b, bc, exp_resp(a), hold + 1); end
      end else begin
        do_read(a, rd, rr, ok, hs);
        checks++; if (!ok || rr !== exp_resp(a) || rd !== exp_read(a, hs)) begin errors++;
          $display("FAIL rnd_read: addr %h rresp %b rdata %h want %b %h", a, rr, rd, exp_resp(a), exp_read(a, hs)); end
      end
      checks++; if (mtime !== mtime_at(cyc) || msip !== m_msip || mtip !== (mtime_at(cyc) >= m_cmp)) begin
        errors++; $display("FAIL rnd_state: mtime %h msip %b mtip %b want %h %b %b", mtime, msip, mtip,
                           mtime_at(cyc), m_msip, (mtime_at(cyc) >= m_cmp)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d, hs, cc; logic [1:0] r; bit ok; int bc;
    do_write(BASE, 64'd1, 8'hFF, 0, 0, r, bc, cc);
    @(negedge clk);
    awaddr = BASE + 64'h4000; awvalid = 1'b1;
    @(negedge clk); awvalid = 1'b0;
    checks++; if ({awready, wready} !== 2'b01) begin errors++;
      $display("FAIL rstmid_waitw: got %b want 01", {awready, wready}); end
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_reset();
    wdata = 64'h55; wvalid = 1'b0;
    checks++; if (bvalid !== 1'b0 || mtime !== 64'd0 || msip !== 1'b0 || mtip !== 1'b0) begin errors++;
      $display("FAIL rstmid_state: bvalid %b mtime %h msip %b mtip %b want 0 0 0 0", bvalid, mtime, msip, mtip); end
    do_read(BASE + 64'h4000, d, r, ok, hs);
    checks++; if (d !== ONES || bvalid !== 1'b0) begin errors++;
      $display("FAIL rstmid_cmp: rdata %h bvalid %b want %h 0", d, bvalid, ONES); end
    do_write(BASE, 64'd1, 8'hFF, -1, 0, r, bc, cc);
    model_write(BASE, 64'd1, 8'hFF, cc);
    checks++; if (r !== 2'b00 || bc !== 1 || msip !== 1'b1) begin errors++;
      $display("FAIL rstmid_fresh: bresp %b bcyc %0d msip %b want 00 1 1", r, bc, msip); end
  endtask

  initial begin
    rstn = 1'b0;
    awaddr = 64'd0; awvalid = 1'b0; wdata = 64'd0; wstrb = 8'd0; wvalid = 1'b0; bready = 1'b0;
    araddr = 64'd0; arvalid = 1'b0; rready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    test_reset();
    test_mtime_read();
    test_timer_cmp();
    test_w_before_aw();
    test_errors();
    test_wrap();
    test_wstrb();
    test_simul();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_lite_clint_slave.md
# axi_lite_clint_slave

AXI-lite responder implementing the core-local timer/software-interrupt device (mtime, mtimecmp, msip). It sits on the MMIO side of the SoC interconnect, answering the MMIO master's single-beat AXI-lite reads and writes, and drives the machine timer and software interrupt lines back to the core. It is the slave end of the same AXI-lite protocol the core wrapper initiates.

## Interface
- ADDR_WIDTH, 64, AXI address width
- DATA_WIDTH, 64, AXI data width (fixed 64; registers are 64-bit)
- BASE_ADDR, 64'h0200_0000, device base; window is BASE_ADDR..BASE_ADDR+0xFFFF
- clk  input  1  clock, all logic on rising edge
- rstn  input  1  reset, asynchronous, active-low
- awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  write-address channel
- wdata/wstrb/wvalid/wready  in/in/in/out  64/8/1/1  write-data channel
- bresp/bvalid/bready  out/out/in  2/1/1  write-response channel
- araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  read-address channel
- rdata/rresp/rvalid/rready  out/out/out/in  64/2/1/1  read-data channel
- mtip  output  1  timer interrupt pending
- msip  output  1  software interrupt pending
- mtime  output  64  current timer value (for cosim/CSR time)

## Operation
- Register map (offset = addr − BASE_ADDR): 0x0000 msip (bit 0, others read 0); 0x4000 mtimecmp; 0xBFF8 mtime.
- Responses: OKAY 2'b00 on hit; SLVERR 2'b10 if addr[2:0]≠0; DECERR 2'b11 if outside window or unmapped offset. Error writes change nothing; error reads return rdata 0.
- Write FSM: WR_IDLE (awready=wready=1) → both handshake same cycle: commit, WR_RESP; only AW: latch addr, WR_WAIT_W (wready=1, awready=0); only W: latch data/strb, WR_WAIT_AW (awready=1, wready=0). WAIT states → WR_RESP on missing handshake, commit then. WR_RESP: bvalid=1, no readies; → WR_IDLE on bready.
- Read FSM: RD_IDLE (arready=1) → AR handshake: register rdata/rresp, RD_RESP. RD_RESP: rvalid=1, arready=0; → RD_IDLE on rready. rdata/rresp stable while rvalid&&!rready.
- mtime += 1 every cycle, wraps 0xFFFF_FFFF_FFFF_FFFF → 0.
- mtip = (mtime ≥ mtimecmp), unsigned 64-bit, combinational from registers. msip = msip register bit 0.
- Simultaneous: write to mtime beats increment (written value loaded, no +1 that cycle); read and write to same register in one cycle: read returns old value. Read and write channels fully independent.

## Timing
- Reset values: awready=wready=arready=1, bvalid=rvalid=0, bresp=rresp=0, rdata=0, mtime=0, mtimecmp=all ones, msip=0, mtip=0.
- Write commit on the edge of the completing handshake; bvalid and new register value visible next cycle; mtip updates same cycle as new value.
- Read latency: rvalid one cycle after AR handshake; rdata samples register value at handshake edge.
- Back-to-back: new AR accepted the cycle after rready handshake (one idle cycle between reads); same for writes.
- Reset mid-transaction: FSMs return to IDLE, pending latched write is discarded, no response emitted.

## Configuration
- CLINT_WSTRB_EN defined: wstrb honored per byte (byte i written iff wstrb[i]); msip takes bit 0 only when wstrb[0].
- Undefined: wstrb ignored, every OKAY write replaces the full 64-bit register.

## Structure
- Package ClintStruct: offset constants (MSIP_OFF, MTIMECMP_OFF, MTIME_OFF), response codes (RESP_OKAY/SLVERR/DECERR), write and read FSM state enums.
- One sub-module clint_timer_regs: mtime counter, mtimecmp, msip, strobe merge, mtip compare; the top holds the two AXI FSMs and decode.

## Test plan
- After reset, read 0xBFF8 at cycle 10 → rresp 00, rdata ≈ 10 (exact cycle count checked), mtip=0.
- Write mtimecmp=0x20 (AW and W same cycle) → bresp 00 next cycle; mtip rises exactly when mtime reaches 0x20.
- W 3 cycles before AW to 0x0000 data 1 → no commit until AW; msip=1 the cycle after AW handshake; bvalid held 5 cycles with bready low.
- Read 0x0004 → SLVERR; read BASE+0x10000 → DECERR, rdata 0; write 0x8000 → DECERR, no register changes.
- Write mtime=0xFFFF_FFFF_FFFF_FFFE → reads 0xFFFF_FFFF_FFFF_FFFF next cycle then 0 (wrap); with CLINT_WSTRB_EN, wstrb=0x01 data 0xAB to mtimecmp=all ones → 0xFFFF_FFFF_FFFF_FFAB.
- Assert rstn low during WR_WAIT_W → no bvalid, registers at reset values, FSM accepts a fresh write afterwards.
